// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 256-bit memory port between dcache (p0)
// and icache (p1); one transaction in flight, with a sticky ack watchdog.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         p0_enable_i,
    input  logic         p0_write_i,
    input  logic [31:0]  p0_addr_i,
    input  logic [255:0] p0_data_i,
    output logic         p0_ack_o,
    output logic [255:0] p0_data_o,
    input  logic         p1_enable_i,
    input  logic         p1_write_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [255:0] p1_data_i,
    output logic         p1_ack_o,
    output logic [255:0] p1_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic         mem_ack_i,
    input  logic [255:0] mem_data_i,
    output logic [1:0]   grant_o,
    output logic         timeout_o
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [7:0] LP_TO = 8'(TIMEOUT_CYCLES);

    state_t         r_state;
    logic           r_prio;
    logic [7:0]     r_wd;
    logic           r_timeout;
    logic           r_mem_en;
    logic           r_mem_wr;
    logic [31:0]    r_mem_addr;
    logic [255:0]   r_mem_data;
    logic [1:0]     r_grant;

    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_busy;
    logic [7:0]     w_wd_next;

    // r_prio = 0 favours p0 on a tie, 1 favours p1
    assign w_gnt0    = p0_enable_i & (~p1_enable_i | ~r_prio);
    assign w_gnt1    = p1_enable_i & (~p0_enable_i | r_prio);
    assign w_busy    = (r_state == BUSY);
    assign w_wd_next = (r_wd == LP_TO) ? r_wd : r_wd + 8'd1;

    assign p0_ack_o  = mem_ack_i & w_busy & r_grant[0];
    assign p1_ack_o  = mem_ack_i & w_busy & r_grant[1];
    assign p0_data_o = mem_data_i;
    assign p1_data_o = mem_data_i;

    assign mem_enable_o = r_mem_en;
    assign mem_write_o  = r_mem_wr;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign grant_o      = r_grant;
    assign timeout_o    = r_timeout;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_prio     <= 1'b0;
            r_wd       <= 8'd0;
            r_timeout  <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= 32'd0;
            r_mem_data <= 256'd0;
            r_grant    <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_mem_en   <= 1'b1;
                        r_mem_wr   <= w_gnt0 ? p0_write_i : p1_write_i;
                        r_mem_addr <= w_gnt0 ? p0_addr_i : p1_addr_i;
                        r_mem_data <= w_gnt0 ? p0_data_i : p1_data_i;
                        r_grant    <= {w_gnt1, w_gnt0};
                        r_wd       <= 8'd0;
                        r_state    <= BUSY;
                    end else begin
                        r_mem_en <= 1'b0;
                    end
                end
                BUSY: begin
                    r_wd <= w_wd_next;
                    if (w_wd_next == LP_TO)
                        r_timeout <= 1'b1;
                    if (mem_ack_i) begin
                        r_mem_en <= 1'b0;
                        r_grant  <= 2'b00;
                        r_prio   <= r_grant[0];
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, capture/freeze,
// turnaround, ack routing and watchdog timeout (TIMEOUT_CYCLES = 8).
module tb_mem_port_arbiter;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         p0_enable_i = 1'b0;
    logic         p0_write_i = 1'b0;
    logic [31:0]  p0_addr_i = '0;
    logic [255:0] p0_data_i = '0;
    logic         p0_ack_o;
    logic [255:0] p0_data_o;
    logic         p1_enable_i = 1'b0;
    logic         p1_write_i = 1'b0;
    logic [31:0]  p1_addr_i = '0;
    logic [255:0] p1_data_i = '0;
    logic         p1_ack_o;
    logic [255:0] p1_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i = 1'b0;
    logic [255:0] mem_data_i = '0;
    logic [1:0]   grant_o;
    logic         timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [255:0] LINE_A5 = {32{8'hA5}};
    localparam logic [255:0] LINE_12 = {16{16'h1234}};
    localparam logic [255:0] LINE_WB = {8{32'hDEADBEEF}};

    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i),
        .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i),
        .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        p0_enable_i = 0; p1_enable_i = 0; mem_ack_i = 0;
        rst_i = 0;
        tick(); tick();
        rst_i = 1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (5) tick();
        n_cmp++;
        if ({mem_enable_o, grant_o, p0_ack_o, p1_ack_o, timeout_o} !== 6'b0) begin
            $display("FAIL reset_idle got en=%b gnt=%b ack=%b%b to=%b want 0",
                     mem_enable_o, grant_o, p0_ack_o, p1_ack_o, timeout_o);
            n_err++;
        end
        n_cmp++;
        if (mem_addr_o !== 32'h0 || mem_data_o !== 256'h0) begin
            $display("FAIL reset_bus got addr=%h want 0", mem_addr_o);
            n_err++;
        end
        mem_ack_i = 1; #1;
        n_cmp++;
        if ({p0_ack_o, p1_ack_o} !== 2'b00) begin
            $display("FAIL idle_ack_ignored got %b%b want 00", p0_ack_o, p1_ack_o);
            n_err++;
        end
        tick();
        mem_ack_i = 0;
    endtask

    task automatic test_p0_read();
        p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h400;
        #1;
        n_cmp++;
        if (mem_enable_o !== 1'b0) begin
            $display("FAIL rd_latency got en=%b want 0", mem_enable_o);
            n_err++;
        end
        tick();
        n_cmp++;
        if (mem_enable_o !== 1 || mem_addr_o !== 32'h400 || mem_write_o !== 0 || grant_o !== 2'b01) begin
            $display("FAIL rd_issue got en=%b a=%h w=%b g=%b want 1 400 0 01",
                     mem_enable_o, mem_addr_o, mem_write_o, grant_o);
            n_err++;
        end
        for (int i = 1; i < 10; i++) begin
            tick();
            n_cmp++;
            if (p0_ack_o !== 0 || mem_enable_o !== 1) begin
                $display("FAIL rd_wait%0d got ack=%b en=%b want 0 1", i, p0_ack_o, mem_enable_o);
                n_err++;
            end
        end
        tick();
        mem_ack_i = 1; mem_data_i = LINE_A5;
        #1;
        n_cmp++;
        if (p0_ack_o !== 1 || p1_ack_o !== 0 || p0_data_o !== LINE_A5) begin
            $display("FAIL rd_ack got ack=%b%b d=%h want 10 a5..", p0_ack_o, p1_ack_o, p0_data_o[31:0]);
            n_err++;
        end
        tick();
        mem_ack_i = 0; p0_enable_i = 0;
        #1;
        n_cmp++;
        if (mem_enable_o !== 0 || grant_o !== 2'b00 || p0_ack_o !== 0) begin
            $display("FAIL rd_done got en=%b g=%b ack=%b want 0 00 0", mem_enable_o, grant_o, p0_ack_o);
            n_err++;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h10;
        p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h20;
        tick();
        n_cmp++;
        if (grant_o !== 2'b01 || mem_addr_o !== 32'h10) begin
            $display("FAIL rr_first got g=%b a=%h want 01 10", grant_o, mem_addr_o);
            n_err++;
        end
        tick(); tick();
        mem_ack_i = 1; #1;
        n_cmp++;
        if ({p0_ack_o, p1_ack_o} !== 2'b10) begin
            $display("FAIL rr_ack0 got %b%b want 10", p0_ack_o, p1_ack_o);
            n_err++;
        end
        tick();
        mem_ack_i = 0; p0_enable_i = 0;
        n_cmp++;
        if (grant_o !== 2'b00 || mem_enable_o !== 0) begin
            $display("FAIL rr_gap got g=%b en=%b want 00 0", grant_o, mem_enable_o);
            n_err++;
        end
        tick();
        n_cmp++;
        if (grant_o !== 2'b10 || mem_addr_o !== 32'h20 || mem_enable_o !== 1) begin
            $display("FAIL rr_second got g=%b a=%h want 10 20", grant_o, mem_addr_o);
            n_err++;
        end
        mem_ack_i = 1; #1;
        n_cmp++;
        if ({p0_ack_o, p1_ack_o} !== 2'b01) begin
            $display("FAIL rr_ack1 got %b%b want 01", p0_ack_o, p1_ack_o);
            n_err++;
        end
        tick();
        mem_ack_i = 0;
        p0_enable_i = 1; p0_addr_i = 32'h30;
        p1_addr_i = 32'h40;
        tick();
        n_cmp++;
        if (grant_o !== 2'b01 || mem_addr_o !== 32'h30) begin
            $display("FAIL rr_third got g=%b a=%h want 01 30", grant_o, mem_addr_o);
            n_err++;
        end
        mem_ack_i = 1;
        tick();
        mem_ack_i = 0; p0_enable_i = 0; p1_enable_i = 0;
        tick();
    endtask

    task automatic test_freeze();
        p1_enable_i = 1; p1_write_i = 1; p1_addr_i = 32'h80; p1_data_i = LINE_12;
        tick();
        n_cmp++;
        if (grant_o !== 2'b10 || mem_addr_o !== 32'h80 || mem_write_o !== 1 || mem_data_o !== LINE_12) begin
            $display("FAIL frz_issue got g=%b a=%h w=%b want 10 80 1", grant_o, mem_addr_o, mem_write_o);
            n_err++;
        end
        p1_addr_i = 32'hFF; p1_data_i = ~LINE_12; p1_write_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (mem_addr_o !== 32'h80 || mem_data_o !== LINE_12 || mem_write_o !== 1) begin
                $display("FAIL frz_hold%0d got a=%h w=%b want 80 1", i, mem_addr_o, mem_write_o);
                n_err++;
            end
        end
        mem_ack_i = 1; #1;
        n_cmp++;
        if ({p0_ack_o, p1_ack_o} !== 2'b01) begin
            $display("FAIL frz_ack got %b%b want 01", p0_ack_o, p1_ack_o);
            n_err++;
        end
        tick();
        mem_ack_i = 0; p1_enable_i = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        p0_enable_i = 1; p0_write_i = 1; p0_addr_i = 32'h200; p0_data_i = LINE_WB;
        tick();
        n_cmp++;
        if (grant_o !== 2'b01 || mem_addr_o !== 32'h200 || mem_write_o !== 1 || mem_data_o !== LINE_WB) begin
            $display("FAIL b2b_wb got g=%b a=%h w=%b want 01 200 1", grant_o, mem_addr_o, mem_write_o);
            n_err++;
        end
        tick();
        mem_ack_i = 1; #1;
        n_cmp++;
        if (p0_ack_o !== 1) begin
            $display("FAIL b2b_ack1 got %b want 1", p0_ack_o);
            n_err++;
        end
        p0_write_i = 0; p0_addr_i = 32'h600;
        tick();
        mem_ack_i = 0;
        n_cmp++;
        if (mem_enable_o !== 0 || grant_o !== 2'b00) begin
            $display("FAIL b2b_gap got en=%b g=%b want 0 00", mem_enable_o, grant_o);
            n_err++;
        end
        tick();
        n_cmp++;
        if (mem_enable_o !== 1 || grant_o !== 2'b01 || mem_addr_o !== 32'h600 || mem_write_o !== 0) begin
            $display("FAIL b2b_refill got en=%b g=%b a=%h w=%b want 1 01 600 0",
                     mem_enable_o, grant_o, mem_addr_o, mem_write_o);
            n_err++;
        end
        mem_ack_i = 1;
        tick();
        mem_ack_i = 0; p0_enable_i = 0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        n_cmp++;
        if (timeout_o !== 0) begin
            $display("FAIL to_clear got %b want 0", timeout_o);
            n_err++;
        end
        p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h40;
        tick();
        for (int k = 1; k < 8; k++) begin
            tick();
            n_cmp++;
            if (timeout_o !== 0) begin
                $display("FAIL to_early%0d got %b want 0", k, timeout_o);
                n_err++;
            end
        end
        tick();
        n_cmp++;
        if (timeout_o !== 1 || mem_enable_o !== 1) begin
            $display("FAIL to_rise got to=%b en=%b want 1 1", timeout_o, mem_enable_o);
            n_err++;
        end
        repeat (3) tick();
        n_cmp++;
        if (timeout_o !== 1) begin
            $display("FAIL to_sticky got %b want 1", timeout_o);
            n_err++;
        end
        #2;
        mem_ack_i = 1; rst_i = 0;
        #1;
        n_cmp++;
        if ({mem_enable_o, mem_write_o, grant_o, timeout_o, p0_ack_o, p1_ack_o} !== 7'b0
            || mem_addr_o !== 32'h0 || mem_data_o !== 256'h0) begin
            $display("FAIL async_rst got en=%b g=%b to=%b ack=%b a=%h want 0",
                     mem_enable_o, grant_o, timeout_o, p0_ack_o, mem_addr_o);
            n_err++;
        end
        mem_ack_i = 0; p0_enable_i = 0;
        tick();
        rst_i = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_p0_read();
        test_round_robin();
        test_freeze();
        test_back_to_back();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
